// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the RW0 SRAM port controller.
//   state_e : controller phase (INIT zero-fills the macro, RUN serves requests)
//   grant_e : which request type last won a contended port cycle
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_MASK_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_resp_fifo2.sv
// Two-entry response FIFO holding read data returned by the SRAM macro.
//   clock, reset_n      : clock and asynchronous active-low reset
//   push, push_data     : enqueue one word (ignored when full)
//   pop                 : dequeue the head word (ignored when empty)
//   count               : number of stored words, 0..2
//   head_data           : oldest stored word (undefined when empty)
module sram_resp_fifo2
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop && (count_q != 2'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_rw0_port_ctrl.sv
// Initiator-side controller for the RW0 port of a single-port byte-masked SRAM.
// After reset it zero-fills the whole array (the macro has no reset), then
// arbitrates a write channel and a read channel onto the single port. Read data
// returns one cycle after the read and is parked in a 2-entry FIFO; reads are
// only accepted when that FIFO is guaranteed to have room.
//   clock, reset_n                         : clock, async active-low reset
//   init_done                              : high once requests are accepted
//   w_valid/w_ready/w_addr/w_data/w_mask   : write request channel
//   r_valid/r_ready/r_addr                 : read request channel
//   resp_valid/resp_ready/resp_data        : read response channel
//   sram_en/wmode/addr/wmask/wdata/rdata   : RW0 port of the *_ext macro
module sram_rw0_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MASK_W        = DEF_MASK_W,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [MASK_W-1:0] w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              rd_vld_p1;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        pending;
  logic              deq;
  logic              run;
  logic              rd_elig;
  logic              wr_elig;
  logic              grant_rd;
  logic              grant_wr;

  // Outputs are qualified with reset_n so they drop to 0 the moment reset asserts.
  assign run        = reset_n && (state_q == RUN);
  assign init_done  = run;
  assign resp_valid = (fifo_count != 2'd0);
  assign resp_data  = resp_valid ? fifo_head : '0;
  assign deq        = resp_valid && resp_ready;

  // A read may only launch if its data is sure to find a free FIFO slot when it
  // lands next cycle: stored + in-flight words, minus the one leaving now, < 2.
  assign pending = {1'b0, fifo_count} + {2'b00, rd_vld_p1};
  assign rd_elig = run && r_valid && (pending < (3'd2 + {2'b00, deq}));
  assign wr_elig = run && w_valid;

  always_comb begin
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    last_grant_d = last_grant_q;
    if (rd_elig && wr_elig) begin
      if (last_grant_q == WRITE) begin
        grant_rd     = 1'b1;
        last_grant_d = READ;
      end else begin
        grant_wr     = 1'b1;
        last_grant_d = WRITE;
      end
    end else begin
      grant_rd = rd_elig;
      grant_wr = wr_elig;
    end
  end

  assign r_ready = grant_rd;
  assign w_ready = grant_wr;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (reset_n) begin
      case (state_q)
        INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = init_cnt_q;
          sram_wmask = '1;
          init_cnt_d = init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        end
        RUN: begin
          if (grant_wr) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wmask = w_mask;
            sram_wdata = w_data;
          end else if (grant_rd) begin
            sram_en   = 1'b1;
            sram_addr = r_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RST_STATE;
      init_cnt_q   <= '0;
      last_grant_q <= WRITE;
      rd_vld_p1    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      // Stage p0 -> p1: read launched this cycle, macro data valid next cycle.
      rd_vld_p1    <= grant_rd;
    end
  end

  // Stage p1 -> FIFO: capture macro rdata in the single cycle it is valid.
  sram_resp_fifo2 #(
    .DATA_W(DATA_W)
  ) u_resp_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (rd_vld_p1),
    .push_data(sram_rdata),
    .pop      (deq),
    .count    (fifo_count),
    .head_data(fifo_head)
  );

endmodule

// File: doc/sram_rw0_port_ctrl.md
Name: sram_rw0_port_ctrl

Overview:
- Initiator-side controller that drives the RW0 port of a single-port, byte-masked 256x64 SRAM macro. The macro has 1-cycle read latency, and its rdata is valid only in the cycle after a read.
- Arbitrates independent valid/ready write and read request channels onto the one port. Buffers read data so a stalled consumer never loses data.
- Zero-fills the array after reset, because the macro has no reset. Sits between pipeline logic and the generated `*_ext` macro.

Parameters:
- ADDR_W, 8, SRAM address width.
- DEPTH, 256, number of SRAM entries; equals 2**ADDR_W.
- DATA_W, 64, data width.
- MASK_W, 8, write-mask width; equals DATA_W/8, one bit per byte.
- INIT_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = start directly in RUN.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the controller accepts requests.
- w_valid  in  1  write request valid.
- w_ready  out  1  write request accepted.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- w_mask  in  MASK_W  byte enables.
- r_valid  in  1  read request valid.
- r_ready  out  1  read request accepted.
- r_addr  in  ADDR_W  read address.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  consumer accepts read data.
- resp_data  out  DATA_W  read data.
- sram_en  out  1  to macro RW0_en.
- sram_wmode  out  1  to macro RW0_wmode.
- sram_addr  out  ADDR_W  to macro RW0_addr.
- sram_wmask  out  MASK_W  to macro RW0_wmask.
- sram_wdata  out  DATA_W  to macro RW0_wdata.
- sram_rdata  in  DATA_W  from macro RW0_rdata.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values: all outputs 0. FSM = INIT, or RUN if INIT_ON_RESET=0. Init counter = 0, queue empty, inflight = 0, last_grant = WRITE.
- INIT state:
  - Each cycle: sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter.
  - Counter increments 0..DEPTH-1. After the write to DEPTH-1, move to RUN.
  - init_done rises in the first RUN cycle, exactly DEPTH cycles after reset release.
  - w_ready and r_ready are held 0 during INIT.
- RUN state, handshakes: a request is accepted when valid&&ready in the same cycle. The port op is driven combinationally in that cycle, with sram_en=1.
- RUN state, idle port: sram_en=0, and addr/wmask/wdata are driven 0.
- Read credit:
  - pending = queue count + inflight; deq = resp_valid && resp_ready.
  - A read is eligible only when pending - deq < 2.
  - Writes need no credit.
- Arbitration:
  - Only one eligible request: it is granted.
  - Both eligible: grant the type not in last_grant, then update last_grant.
  - A read blocked by credit never blocks a write.
  - r_ready = RUN && read eligible && granted; w_ready likewise.
- Read pipeline:
  - Read accepted in cycle T: inflight=1 in T+1, and sram_rdata is pushed into the 2-entry FIFO at the end of T+1.
  - resp_valid rises in T+2.
  - With resp_ready held 1, throughput is one read per cycle.
- Ordering:
  - Responses return in request order.
  - A write accepted in cycle T is visible to a read accepted in T+1 or later.
- Hold: resp_data and resp_valid stay stable while resp_valid && !resp_ready.
- Queue full (count=2, no deq): r_ready=0; writes continue.
- Reset mid-operation: reset_n low clears the queue and inflight immediately. resp_valid=0, sram_en=0, FSM returns to INIT, counter = 0. In-flight read data is discarded.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - FSM state typedef: INIT, RUN.
  - Grant typedef: READ, WRITE.
  - Default width and depth constants.
- One sub-module, sram_resp_fifo2: 2-entry response FIFO with count output and async active-low reset.

Test Plan:
- Reset release with INIT_ON_RESET=1: 256 consecutive writes (addr 0..255, wmask 0xFF, wdata 0), then init_done=1 on cycle 256. Then read 0x37 -> resp_data 0x0.
- Write 0x10 data 0x1122334455667788 mask 0x0F accepted in T, read 0x10 accepted in T+1 -> resp_valid at T+3, resp_data 0x0000000055667788.
- resp_ready=0, r_valid held for addrs 1..4 -> exactly 2 accepted, r_ready=0 afterwards. Raise resp_ready -> responses for addrs 1,2 then 3,4, in order.
- w_valid and r_valid both held for 4 cycles after init -> grant order READ, WRITE, READ, WRITE, one per cycle; sram_wmode = 0,1,0,1.
- Queue full with resp_valid=1, then reset_n pulsed low mid-cycle -> resp_valid=0 and sram_en=0 asynchronously. After release, INIT restarts at addr 0.
- 8 back-to-back reads with resp_ready=1 -> r_ready never drops, 8 responses on 8 consecutive cycles starting at T+2.
